sti_dac_sched: RTL and testbench

- Scheduler in front of the serial-transmit/pixel-DAC converter. Arbitrates between N word requesters and drives the converter's parallel load interface one word at a time.
- Monitors the serial output to detect end-of-word, checks the bit count, and sequences the final end request and pixel-finish wait.
- Sits between the packet producers and the converter; its sti_* outputs connect straight to the converter's load/pi_* inputs.

---
 rtl/sti_pkg.sv | 30 +++
 rtl/sti_rr_arb.sv | 48 ++++
 rtl/sti_dac_sched.sv | 156 +++++++++++++++
 tb/tb_sti_dac_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared types and constants for the STI/DAC load scheduler.
// Holds the sequencer states, converter length codes and requester cfg layout.
package sti_pkg;

  localparam int DATA_W = 16;
  localparam int CFG_W  = 5;

  // Requester cfg word is {length[1:0], fill, msb, low}
  localparam int CFG_LOW  = 0;
  localparam int CFG_MSB  = 1;
  localparam int CFG_FILL = 2;
  localparam int CFG_LEN  = 3;

  typedef enum logic [2:0] {
    IDLE, LOAD, START_WAIT, XFER, GAP, END, END_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {
    LEN8  = 2'd0,
    LEN16 = 2'd1,
    LEN24 = 2'd2,
    LEN32 = 2'd3
  } len_t;

  // Serial bits the converter emits for a length code: 8 * (length + 1)
  function automatic logic [5:0] exp_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rr_arb.sv
// N-way round-robin arbiter: combinational grant from a rotating priority pointer.
// The pointer moves to grant+1 only when the caller strobes i_adv on a valid grant.
module sti_rr_arb #(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_elig,
  input  logic                 i_adv,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;

  always_comb begin
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    // Scan farthest offset first so the closest eligible requester wins
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IW + 1)'(k);
      if (w_sum >= (IW + 1)'(N)) w_sum = w_sum - (IW + 1)'(N);
      w_j = w_sum[IW-1:0];
      if (i_elig[w_j]) begin
        o_idx   = w_j;
        o_valid = 1'b1;
      end
    end
    o_grant[o_idx] = o_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_adv && o_valid) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sti_dac_sched.sv
// Load scheduler for the serial-transmit/pixel-DAC converter: arbitrates word
// requesters, checks serial bit counts and sequences the end/pixel-finish handshake.
module sti_dac_sched
  import sti_pkg::*;
#(
  parameter int N           = 4,
  parameter int TIMEOUT     = 16,
  parameter int FIN_TIMEOUT = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N-1:0]        i_req,
  input  logic [16*N-1:0]     i_req_data,
  input  logic [5*N-1:0]      i_req_cfg,
  input  logic [N-1:0]        i_req_last,
  input  logic                i_flush,
  output logic [N-1:0]        o_ack,
  output logic                o_sti_load,
  output logic [15:0]         o_sti_data,
  output logic [1:0]          o_sti_length,
  output logic                o_sti_fill,
  output logic                o_sti_msb,
  output logic                o_sti_low,
  output logic                o_sti_end,
  input  logic                i_sti_so_valid,
  input  logic                i_sti_pixel_finish,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_timeout,
  output logic                o_err_count,
  output logic [15:0]         o_words_sent
);

  state_t                r_state, w_next;
  logic [N-1:0]          r_last_seen;
  logic                  r_flush_pend;
  logic [15:0]           r_cnt;
  logic [5:0]            r_bitcnt;
  logic [5:0]            r_exp;

  logic [N-1:0]          w_grant;
  logic [$clog2(N)-1:0]  w_idx;
  logic                  w_gvalid;
  logic [DATA_W-1:0]     w_data_arr [N];
  logic [CFG_W-1:0]      w_cfg_arr  [N];
  logic [DATA_W-1:0]     w_word;
  logic [CFG_W-1:0]      w_cfg;
  logic                  w_end_req, w_go_load, w_go_end;
  logic                  w_start_to, w_fin_to;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_data_arr[gi] = i_req_data[gi*DATA_W +: DATA_W];
    assign w_cfg_arr[gi]  = i_req_cfg[gi*CFG_W +: CFG_W];
  end

  assign w_word = w_data_arr[w_idx];
  assign w_cfg  = w_cfg_arr[w_idx];

  sti_rr_arb #(.N(N)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_elig  (i_req & ~r_last_seen),
    .i_adv   (w_go_load),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_gvalid)
  );

  // A flush pulse in the same IDLE cycle as a request still wins
  assign w_end_req  = (&r_last_seen) | r_flush_pend | i_flush;
  assign w_start_to = (r_state == START_WAIT) && !i_sti_so_valid && (r_cnt == 16'(TIMEOUT - 1));
  assign w_fin_to   = (r_state == END_WAIT) && !i_sti_pixel_finish && (r_cnt == 16'(FIN_TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_end_req) w_next = END;
                  else if (w_gvalid) w_next = LOAD;
      LOAD:       w_next = START_WAIT;
      START_WAIT: if (i_sti_so_valid) w_next = XFER;
                  else if (w_start_to) w_next = IDLE;
      XFER:       if (!i_sti_so_valid) w_next = GAP;
      GAP:        w_next = IDLE;
      END:        w_next = END_WAIT;
      END_WAIT:   if (i_sti_pixel_finish || w_fin_to) w_next = DONE;
      DONE:       w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  assign w_go_load = (r_state == IDLE) && (w_next == LOAD);
  assign w_go_end  = (r_state == IDLE) && (w_next == END);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_seen   <= '0;
      r_flush_pend  <= 1'b0;
      r_cnt         <= '0;
      r_bitcnt      <= '0;
      r_exp         <= '0;
      o_ack         <= '0;
      o_sti_load    <= 1'b0;
      o_sti_data    <= '0;
      o_sti_length  <= '0;
      o_sti_fill    <= 1'b0;
      o_sti_msb     <= 1'b0;
      o_sti_low     <= 1'b0;
      o_sti_end     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_count   <= 1'b0;
      o_words_sent  <= '0;
    end else begin
      o_sti_load <= w_go_load;
      o_ack      <= w_go_load ? w_grant : '0;
      if (w_go_load) begin
        o_sti_data   <= w_word;
        o_sti_length <= w_cfg[CFG_LEN +: 2];
        o_sti_fill   <= w_cfg[CFG_FILL];
        o_sti_msb    <= w_cfg[CFG_MSB];
        o_sti_low    <= w_cfg[CFG_LOW];
        r_exp        <= exp_bits(w_cfg[CFG_LEN +: 2]);
        o_words_sent <= o_words_sent + 16'd1;
        if (i_req_last[w_idx]) r_last_seen <= r_last_seen | w_grant;
      end

      if (w_go_end)     r_flush_pend <= 1'b0;
      else if (i_flush) r_flush_pend <= 1'b1;

      // One counter serves both the start wait and the pixel-finish wait
      if (w_go_load || w_go_end)
        r_cnt <= '0;
      else if (r_state inside {LOAD, START_WAIT, END, END_WAIT})
        r_cnt <= r_cnt + 16'd1;

      if (r_state == START_WAIT && i_sti_so_valid)
        r_bitcnt <= 6'd1;
      else if (r_state == XFER && i_sti_so_valid && r_bitcnt != 6'd63)
        r_bitcnt <= r_bitcnt + 6'd1;

      if (r_state == XFER && !i_sti_so_valid && r_bitcnt != r_exp) o_err_count <= 1'b1;
      if (w_start_to || w_fin_to) o_err_timeout <= 1'b1;

      o_sti_end <= (w_next == END) || (w_next == END_WAIT);
      o_busy    <= (w_next != IDLE) && (w_next != DONE);
      if (w_next == DONE) o_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sti_dac_sched.sv
// Directed bench for sti_dac_sched: a simple converter model driven inline,
// with hand-computed expectations checked by immediate assertions.
module tb_sti_dac_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [16*N-1:0] req_data = '0;
  logic [5*N-1:0]  req_cfg = '0;
  logic [N-1:0]  req_last = '0;
  logic          flush = 1'b0;
  logic          so_valid = 1'b0;
  logic          pix = 1'b0;

  logic [N-1:0]  ack;
  logic          sti_load, sti_fill, sti_msb, sti_low, sti_end;
  logic [15:0]   sti_data;
  logic [1:0]    sti_length;
  logic          busy, done, err_timeout, err_count;
  logic [15:0]   words_sent;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sti_dac_sched #(.N(N), .TIMEOUT(16), .FIN_TIMEOUT(1024)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req              (req),
    .i_req_data         (req_data),
    .i_req_cfg          (req_cfg),
    .i_req_last         (req_last),
    .i_flush            (flush),
    .o_ack              (ack),
    .o_sti_load         (sti_load),
    .o_sti_data         (sti_data),
    .o_sti_length       (sti_length),
    .o_sti_fill         (sti_fill),
    .o_sti_msb          (sti_msb),
    .o_sti_low          (sti_low),
    .o_sti_end          (sti_end),
    .i_sti_so_valid     (so_valid),
    .i_sti_pixel_finish (pix),
    .o_busy             (busy),
    .o_done             (done),
    .o_err_timeout      (err_timeout),
    .o_err_count        (err_count),
    .o_words_sent       (words_sent)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    so_valid = 1'b0;
    flush = 1'b0;
    pix = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a load pulse and returns the ack vector seen with it
  task automatic wait_load(input bit clr, output logic [N-1:0] a);
    int n = 0;
    while (sti_load !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("load_seen", 32'(sti_load), 32'd1);
    a = ack;
    if (clr) req = req & ~ack;
    $display("xfer: load ack=%b data=0x%04h len=%0d words=%0d", ack, sti_data, sti_length, words_sent);
  endtask

  // Converter model: so_valid starts one cycle after load and lasts nbits cycles
  task automatic xfer_word(input bit clr, input int nbits, output logic [N-1:0] a, output logic [15:0] d);
    wait_load(clr, a);
    d = sti_data;
    @(negedge clk);
    check("load_pulse_width", 32'({sti_load, ack}), 32'd0);
    so_valid = 1'b1;
    repeat (nbits) @(negedge clk);
    so_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] a;
    logic [15:0]  d;
    int n, loads;

    // Reset state
    @(negedge clk);
    check("rst_flags", 32'({sti_load, sti_end, busy, done, err_timeout, err_count, ack}), 32'd0);
    check("rst_data", 32'({sti_data, words_sent}), 32'd0);
    rst_n = 1'b1;

    // 1: single 16-bit word
    req_cfg[4:0] = 5'b01000;
    req_data[15:0] = 16'hA5C3;
    req[0] = 1'b1;
    xfer_word(1'b1, 16, a, d);
    check("t1_ack", 32'(a), 32'b0001);
    check("t1_data", 32'(d), 32'hA5C3);
    repeat (3) @(negedge clk);
    check("t1_words", 32'(words_sent), 32'd1);
    check("t1_errs", 32'({err_timeout, err_count}), 32'd0);
    check("t1_data_held", 32'(sti_data), 32'hA5C3);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: round-robin with all requesters held high
    do_reset();
    req_cfg = '0;
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      xfer_word(1'b0, 8, a, d);
      check("t2_rr_ack", 32'(a), 32'(1) << (k % 4));
      check("t2_rr_data", 32'(d), 32'h1111 * ((k % 4) + 1));
    end
    req = '0;
    repeat (3) @(negedge clk);
    check("t2_words", 32'(words_sent), 32'd8);
    check("t2_no_err", 32'(err_count), 32'd0);

    // 3: 32-bit word but only 31 serial bits
    req_cfg[9:5] = 5'b11000;
    req_data[31:16] = 16'hBEEF;
    req[1] = 1'b1;
    xfer_word(1'b1, 31, a, d);
    check("t3_ack", 32'(a), 32'b0010);
    check("t3_len", 32'(sti_length), 32'd3);
    @(negedge clk);
    check("t3_err_count", 32'(err_count), 32'd1);
    check("t3_no_timeout", 32'(err_timeout), 32'd0);
    repeat (2) @(negedge clk);
    check("t3_idle", 32'(busy), 32'd0);

    // 4: converter never answers
    req[2] = 1'b1;
    wait_load(1'b1, a);
    check("t4_ack", 32'(a), 32'b0100);
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_cycles", 32'(n), 32'd16);
    check("t4_idle", 32'(busy), 32'd0);
    req[3] = 1'b1;
    xfer_word(1'b1, 8, a, d);
    check("t4_next_ack", 32'(a), 32'b1000);
    repeat (3) @(negedge clk);
    check("t4_words", 32'(words_sent), 32'd11);
    check("t4_err_count_sticky", 32'(err_count), 32'd1);

    // 5: each requester sends its last word, then the end handshake
    req_last = 4'b1111;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      xfer_word(1'b1, 8, a, d);
      check("t5_ack", 32'(a), 32'(1) << k);
    end
    n = 0;
    while (sti_end !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_end_delay", 32'(n), 32'd3);
    check("t5_busy", 32'(busy), 32'd1);
    loads = 0;
    repeat (300) begin
      @(negedge clk);
      loads += int'(sti_load);
    end
    check("t5_no_load", 32'(loads), 32'd0);
    check("t5_end_held", 32'(sti_end), 32'd1);
    pix = 1'b1;
    @(negedge clk);
    pix = 1'b0;
    check("t5_done", 32'({done, busy, sti_end}), 32'b100);
    req = 4'b1111;
    repeat (5) @(negedge clk);
    check("t5_terminal", 32'({done, sti_load, ack}), 32'h20);
    req = '0;

    // 6a: flush mid-transfer lets the word finish, then ends; pending req ignored
    do_reset();
    req_last = '0;
    req_cfg[4:0] = 5'b01000;
    req_data[15:0] = 16'h5A5A;
    req = 4'b0011;
    wait_load(1'b1, a);
    check("t6_ack", 32'(a), 32'b0001);
    @(negedge clk);
    so_valid = 1'b1;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (7) @(negedge clk);
    so_valid = 1'b0;
    n = 0;
    loads = 0;
    while (sti_end !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      loads += int'(sti_load);
    end
    check("t6_flush_end_delay", 32'(n), 32'd3);
    check("t6_no_more_loads", 32'(loads), 32'd0);
    check("t6_no_err", 32'(err_count), 32'd0);
    check("t6_words", 32'(words_sent), 32'd1);

    // 6b: asynchronous reset in the middle of a transfer
    do_reset();
    req = 4'b0100;
    wait_load(1'b1, a);
    check("t6_pre_ack", 32'(a), 32'b0100);
    @(negedge clk);
    so_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_flags", 32'({sti_load, sti_end, busy, done, ack}), 32'd0);
    check("t6_async_data", 32'({sti_data, words_sent}), 32'd0);
    @(negedge clk);
    so_valid = 1'b0;
    rst_n = 1'b1;
    req = 4'b1111;
    xfer_word(1'b1, 16, a, d);
    check("t6_restart_ptr0", 32'(a), 32'b0001);
    check("t6_restart_data", 32'(d), 32'h5A5A);
    req = '0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
